// File: rtl/instr_encoder.sv
// ---------------------------------------------------------------------------------------------
// instr_encoder
//   Packs opcode, register fields and a signed 32-bit immediate into an RV32I instruction word
//   (I/Load/JALR, S, B and J formats). Each request is checked for a known opcode, alignment
//   (B/J) and immediate range. A good request becomes a word in a one-entry output register,
//   tagged with a sequential byte address. A rejected request is consumed without producing a
//   word and is recorded in the error status.
//
// Parameters
//   BASE_ADDR  byte address of the first emitted instruction
//   CNT_W      width of the emitted-word and error counters
//
// Ports
//   clk, rst                       clock, synchronous active-high reset
//   in_valid / in_ready            request handshake
//   in_opcode, in_rd, in_rs1,
//   in_rs2, in_funct3, in_imm      request fields (imm is a signed byte offset for B/J)
//   out_valid / out_ready          output word handshake
//   out_instr, out_addr            encoded word and its byte address
//   err_sticky, err_cause          first-error flag and cause (01 opcode, 10 range, 11 align)
//   inst_cnt, err_cnt              saturating counts of handed-off words and rejected requests
// ---------------------------------------------------------------------------------------------
module instr_encoder #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [6:0]       in_opcode,
    input  logic [4:0]       in_rd,
    input  logic [4:0]       in_rs1,
    input  logic [4:0]       in_rs2,
    input  logic [2:0]       in_funct3,
    input  logic [31:0]      in_imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic [31:0]      out_addr,
    output logic             err_sticky,
    output logic [1:0]       err_cause,
    output logic [CNT_W-1:0] inst_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    localparam logic [6:0] OpLoad  = 7'b0000011;
    localparam logic [6:0] OpImm   = 7'b0010011;
    localparam logic [6:0] OpJalr  = 7'b1100111;
    localparam logic [6:0] OpStore = 7'b0100011;
    localparam logic [6:0] OpBr    = 7'b1100011;
    localparam logic [6:0] OpJal   = 7'b1101111;

    localparam logic [1:0] CauseNone  = 2'b00;
    localparam logic [1:0] CauseOp    = 2'b01;
    localparam logic [1:0] CauseRange = 2'b10;
    localparam logic [1:0] CauseAlign = 2'b11;

    typedef enum logic [2:0] {FmtBad, FmtI, FmtS, FmtB, FmtJ} fmt_e;

    fmt_e               fmt;
    logic signed [31:0] imm_s;
    logic signed [31:0] imm_lo;
    logic signed [31:0] imm_hi;
    logic               misaligned;
    logic               in_range;
    logic [1:0]         cause;
    logic [31:0]        enc_word;

    logic               valid_q, valid_d;
    logic [31:0]        instr_q, instr_d;
    logic [31:0]        addr_q, addr_d;
    logic               sticky_q, sticky_d;
    logic [1:0]         cause_q, cause_d;
    logic [CNT_W-1:0]   icnt_q, icnt_d;
    logic [CNT_W-1:0]   ecnt_q, ecnt_d;

    logic               out_hs;
    logic               accept;
    logic               good;
    logic               bad;

    assign imm_s = $signed(in_imm);

    // Format decode and per-format immediate limits.
    always_comb begin
        fmt    = FmtBad;
        imm_lo = 32'sd0;
        imm_hi = 32'sd0;
        unique case (in_opcode)
            OpLoad, OpImm, OpJalr: begin
                fmt    = FmtI;
                imm_lo = -32'sd2048;
                imm_hi = 32'sd2047;
            end
            OpStore: begin
                fmt    = FmtS;
                imm_lo = -32'sd2048;
                imm_hi = 32'sd2047;
            end
            OpBr: begin
                fmt    = FmtB;
                imm_lo = -32'sd4096;
                imm_hi = 32'sd4094;
            end
            OpJal: begin
                fmt    = FmtJ;
                imm_lo = -32'sd1048576;
                imm_hi = 32'sd1048574;
            end
            default: fmt = FmtBad;
        endcase
    end

    assign misaligned = ((fmt == FmtB) || (fmt == FmtJ)) && in_imm[0];
    assign in_range   = (imm_s >= imm_lo) && (imm_s <= imm_hi);

    // Checks in priority order: opcode, then alignment, then range.
    always_comb begin
        if (fmt == FmtBad) begin
            cause = CauseOp;
        end else if (misaligned) begin
            cause = CauseAlign;
        end else if (!in_range) begin
            cause = CauseRange;
        end else begin
            cause = CauseNone;
        end
    end

    always_comb begin
        enc_word = 32'h0;
        unique case (fmt)
            FmtI: enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
            FmtS: enc_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
            FmtB: enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                              in_imm[4:1], in_imm[11], in_opcode};
            FmtJ: enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                              in_rd, in_opcode};
            default: enc_word = 32'h0;
        endcase
    end

    assign in_ready = !valid_q || out_ready;
    assign out_hs   = valid_q && out_ready;
    assign accept   = in_valid && in_ready;
    assign good     = accept && (cause == CauseNone);
    assign bad      = accept && (cause != CauseNone);

    always_comb begin
        valid_d  = good || (valid_q && !out_ready);
        instr_d  = good ? enc_word : instr_q;
        // addr_q always holds the address the next loaded word will carry, so a reload in the
        // same cycle as a handoff naturally picks up the advanced address.
        addr_d   = out_hs ? addr_q + 32'd4 : addr_q;
        icnt_d   = (out_hs && (icnt_q != {CNT_W{1'b1}})) ? icnt_q + CNT_W'(1) : icnt_q;
        ecnt_d   = (bad && (ecnt_q != {CNT_W{1'b1}})) ? ecnt_q + CNT_W'(1) : ecnt_q;
        sticky_d = sticky_q;
        cause_d  = cause_q;
        if (bad && !sticky_q) begin
            sticky_d = 1'b1;
            cause_d  = cause;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q  <= 1'b0;
            instr_q  <= 32'h0;
            addr_q   <= BASE_ADDR;
            sticky_q <= 1'b0;
            cause_q  <= CauseNone;
            icnt_q   <= '0;
            ecnt_q   <= '0;
        end else begin
            valid_q  <= valid_d;
            instr_q  <= instr_d;
            addr_q   <= addr_d;
            sticky_q <= sticky_d;
            cause_q  <= cause_d;
            icnt_q   <= icnt_d;
            ecnt_q   <= ecnt_d;
        end
    end

    assign out_valid  = valid_q;
    assign out_instr  = instr_q;
    assign out_addr   = addr_q;
    assign err_sticky = sticky_q;
    assign err_cause  = cause_q;
    assign inst_cnt   = icnt_q;
    assign err_cnt    = ecnt_q;

endmodule

// File: tb/tb_instr_encoder.sv
// ---------------------------------------------------------------------------------------------
// tb_instr_encoder
//   Directed cases followed by randomized traffic against a behavioural model of the encoder.
//   Small counters and a base address near the top of the address space exercise saturation
//   and address wrap.
// ---------------------------------------------------------------------------------------------
module tb_instr_encoder;

    localparam logic [31:0] BASE = 32'hFFFF_FFF0;
    localparam int unsigned CW   = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [6:0]    in_opcode;
    logic [4:0]    in_rd;
    logic [4:0]    in_rs1;
    logic [4:0]    in_rs2;
    logic [2:0]    in_funct3;
    logic [31:0]   in_imm;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_instr;
    logic [31:0]   out_addr;
    logic          err_sticky;
    logic [1:0]    err_cause;
    logic [CW-1:0] inst_cnt;
    logic [CW-1:0] err_cnt;

    instr_encoder #(
        .BASE_ADDR (BASE),
        .CNT_W     (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_opcode  (in_opcode),
        .in_rd      (in_rd),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .in_funct3  (in_funct3),
        .in_imm     (in_imm),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_instr  (out_instr),
        .out_addr   (out_addr),
        .err_sticky (err_sticky),
        .err_cause  (err_cause),
        .inst_cnt   (inst_cnt),
        .err_cnt    (err_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    endtask

    // Behavioural model state.
    logic        m_valid;
    logic [31:0] m_instr;
    logic [31:0] m_addr;
    logic        m_sticky;
    logic [1:0]  m_cause;
    int          m_icnt;
    int          m_ecnt;
    localparam int CntMax = (1 << CW) - 1;

    function automatic bit op_known(input logic [6:0] op);
        return op inside {7'b0000011, 7'b0010011, 7'b1100111, 7'b0100011, 7'b1100011, 7'b1101111};
    endfunction

    function automatic logic [1:0] ref_cause(input logic [6:0] op, input logic [31:0] imm);
        int s;
        int lo;
        int hi;
        s = int'($signed(imm));
        if (!op_known(op)) return 2'b01;
        if ((op == 7'b1100011 || op == 7'b1101111) && (s % 2 != 0)) return 2'b11;
        if (op == 7'b1100011) begin lo = -4096; hi = 4094; end
        else if (op == 7'b1101111) begin lo = -1048576; hi = 1048574; end
        else begin lo = -2048; hi = 2047; end
        if (s < lo || s > hi) return 2'b10;
        return 2'b00;
    endfunction

    // Encoding built from shifted and masked fields.
    function automatic logic [31:0] ref_encode(input logic [6:0] op, input logic [4:0] rd,
                                               input logic [4:0] rs1, input logic [4:0] rs2,
                                               input logic [2:0] f3, input logic [31:0] imm);
        int unsigned u, o, d, a, b, f;
        u = imm; o = op; d = rd; a = rs1; b = rs2; f = f3;
        case (op)
            7'b0100011:
                return ((u >> 5) & 32'h7f) << 25 | b << 20 | a << 15 | f << 12
                       | (u & 32'h1f) << 7 | o;
            7'b1100011:
                return ((u >> 12) & 1) << 31 | ((u >> 5) & 32'h3f) << 25 | b << 20 | a << 15
                       | f << 12 | ((u >> 1) & 32'hf) << 8 | ((u >> 11) & 1) << 7 | o;
            7'b1101111:
                return ((u >> 20) & 1) << 31 | ((u >> 1) & 32'h3ff) << 21
                       | ((u >> 11) & 1) << 20 | ((u >> 12) & 32'hff) << 12 | d << 7 | o;
            default:
                return (u & 32'hfff) << 20 | a << 15 | f << 12 | d << 7 | o;
        endcase
    endfunction

    // Compare outputs against the model mid-cycle, then advance the model across one edge.
    task automatic cycle();
        bit          rdy, hs, acc;
        logic [1:0]  c;
        logic        n_valid, n_sticky;
        logic [31:0] n_instr, n_addr;
        logic [1:0]  n_cause;
        int          n_icnt, n_ecnt;
        #2;
        check_eq("out_valid", out_valid, m_valid);
        check_eq("in_ready", in_ready, !m_valid || out_ready);
        if (m_valid) check_eq("out_instr", out_instr, m_instr);
        check_eq("out_addr", out_addr, m_addr);
        check_eq("err_sticky", err_sticky, m_sticky);
        check_eq("err_cause", err_cause, m_cause);
        check_eq("inst_cnt", inst_cnt, m_icnt);
        check_eq("err_cnt", err_cnt, m_ecnt);
        if (rst) begin
            n_valid = 0; n_instr = 0; n_addr = BASE; n_sticky = 0; n_cause = 0;
            n_icnt = 0; n_ecnt = 0;
        end else begin
            rdy = !m_valid || out_ready;
            hs  = m_valid && out_ready;
            acc = in_valid && rdy;
            c   = ref_cause(in_opcode, in_imm);
            n_valid = m_valid && !out_ready;
            n_instr = m_instr;
            n_addr  = hs ? m_addr + 32'd4 : m_addr;
            n_icnt  = (hs && m_icnt < CntMax) ? m_icnt + 1 : m_icnt;
            n_ecnt  = m_ecnt;
            n_sticky = m_sticky;
            n_cause  = m_cause;
            if (acc && c == 2'b00) begin
                n_valid = 1;
                n_instr = ref_encode(in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_imm);
            end
            if (acc && c != 2'b00) begin
                if (m_ecnt < CntMax) n_ecnt = m_ecnt + 1;
                if (!m_sticky) begin n_sticky = 1; n_cause = c; end
            end
        end
        @(posedge clk);
        #1;
        m_valid = n_valid; m_instr = n_instr; m_addr = n_addr; m_sticky = n_sticky;
        m_cause = n_cause; m_icnt = n_icnt; m_ecnt = n_ecnt;
    endtask

    task automatic req(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [2:0] f3, input logic [31:0] imm);
        in_valid = 1; in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
        in_funct3 = f3; in_imm = imm;
        cycle();
        in_valid = 0;
    endtask

    task automatic idle();
        in_valid = 0;
        cycle();
    endtask

    task automatic do_reset();
        rst = 1;
        cycle();
        rst = 0;
    endtask

    logic [6:0] good_ops [6] = '{7'b0000011, 7'b0010011, 7'b1100111,
                                 7'b0100011, 7'b1100011, 7'b1101111};
    int bnd [14] = '{0, 2047, -2048, 2048, -2049, 4094, -4096, 4096, -4098,
                     1048574, -1048576, 1048576, -1048578, 4095};

    initial begin
        rst = 1; in_valid = 0; out_ready = 1;
        in_opcode = 0; in_rd = 0; in_rs1 = 0; in_rs2 = 0; in_funct3 = 0; in_imm = 0;
        m_valid = 0; m_instr = 0; m_addr = BASE; m_sticky = 0; m_cause = 0;
        m_icnt = 0; m_ecnt = 0;
        @(posedge clk); #1;
        do_reset();
        #1;
        check_eq("rst_out_valid", out_valid, 1'b0);
        check_eq("rst_out_instr", out_instr, 32'h0);
        check_eq("rst_out_addr", out_addr, BASE);

        // Single I, S, B, J words.
        req(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 32'd5);
        #1 check_eq("t1_instr", out_instr, 32'h0050_0093);
        check_eq("t1_addr", out_addr, BASE);
        req(7'b0100011, 5'd0, 5'd0, 5'd2, 3'b010, 32'd8);
        #1 check_eq("t2_s_instr", out_instr, 32'h0020_2423);
        req(7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, -32'sd4);
        #1 check_eq("t2_b_instr", out_instr, 32'hFE00_0EE3);
        req(7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 32'd2048);
        #1 check_eq("t3_j_instr", out_instr, 32'h0010_00EF);
        req(7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 32'd1048576);
        #1 check_eq("t3_cause", err_cause, 2'b10);
        check_eq("t3_err_cnt", err_cnt, 32'd1);
        idle();

        // First error wins; rejected requests leave the address alone.
        do_reset();
        req(7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 32'd3);
        req(7'b0110011, 5'd0, 5'd0, 5'd0, 3'd0, 32'd0);
        #1 check_eq("t4_cause", err_cause, 2'b11);
        check_eq("t4_err_cnt", err_cnt, 32'd2);
        check_eq("t4_addr", out_addr, BASE);
        check_eq("t4_no_word", out_valid, 1'b0);

        // Back-to-back with a stall, then reset while a word is pending.
        do_reset();
        req(7'b0000011, 5'd3, 5'd4, 5'd0, 3'd2, 32'd16);
        out_ready = 0;
        req(7'b0010011, 5'd5, 5'd6, 5'd0, 3'd0, -32'sd1);
        req(7'b0010011, 5'd5, 5'd6, 5'd0, 3'd0, -32'sd1);
        out_ready = 1;
        req(7'b0010011, 5'd5, 5'd6, 5'd0, 3'd0, -32'sd1);
        req(7'b1100111, 5'd7, 5'd8, 5'd0, 3'd0, 32'd100);
        idle();
        #1 check_eq("t5_inst_cnt", inst_cnt, 32'd3);
        check_eq("t5_addr", out_addr, BASE + 32'd12);
        out_ready = 0;
        req(7'b0010011, 5'd1, 5'd1, 5'd0, 3'd0, 32'd1);
        do_reset();
        #1 check_eq("t6_valid", out_valid, 1'b0);
        check_eq("t6_addr", out_addr, BASE);
        check_eq("t6_inst_cnt", inst_cnt, 32'd0);
        out_ready = 1;

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            rst       = ($urandom_range(0, 299) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            in_opcode = ($urandom_range(0, 7) == 0) ? 7'($urandom)
                                                    : good_ops[$urandom_range(0, 5)];
            in_rd     = 5'($urandom);
            in_rs1    = 5'($urandom);
            in_rs2    = 5'($urandom);
            in_funct3 = 3'($urandom);
            case ($urandom_range(0, 3))
                0:       in_imm = 32'($urandom_range(0, 8191)) - 32'd4096;
                1:       in_imm = bnd[$urandom_range(0, 13)];
                2:       in_imm = 32'($urandom_range(0, 2097151)) - 32'd1048576;
                default: in_imm = $urandom;
            endcase
            if ($urandom_range(0, 3) != 0 && in_imm[0] && bnd[13] != 0) in_imm[0] = 1'b0;
            cycle();
        end
        rst = 0;
        in_valid = 0;
        idle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
